// File: rtl/alu_pipe_pkg.sv
// Shared opcode/state encodings and opcode classification helpers for the execute unit.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_NOT  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_SRA  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_BEQZ = 4'b0110,
    OP_BNEZ = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_SUB  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT
  } state_t;

  // Branches and the undefined (NOP) encodings never touch the register file.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_SUB) && (op != OP_BEQZ) && (op != OP_BNEZ);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_regfile_pipe_alu_core.sv
// Combinational ADD/SUB/logic/branch evaluation; shift ops pass operand a through
// (a zero-length shift), the multi-cycle shifter lives in the parent FSM.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              take_branch
);

  localparam int M = DATA_W - 1;

  always_comb begin
    result      = '0;
    ovf         = 1'b0;
    take_branch = 1'b0;
    case (op)
      OP_ADD: begin
        result = a + b;
        ovf    = (a[M] == b[M]) && (result[M] != a[M]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a[M] != b[M]) && (result[M] != a[M]);
      end
      OP_NOT:  result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SRA,
      OP_SLL:  result = a;
      OP_BEQZ: take_branch = (a == '0);
      OP_BNEZ: take_branch = (a != '0);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Register file + registered ALU stage with forwarding and a bit-serial shifter.
// Results 2 edges after issue (shifts: amount+1); in_ready drops while a shift has >1 step left.
module alu_regfile_pipe
  import alu_pipe_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  NUM_REGS = 8,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic [AW-1:0]     rd_addr,
  input  logic              wb_en,
  input  logic              src1_zero,
  input  logic              src2_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_ovf,
  output logic              out_take_branch
);

  localparam int                CW   = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] DW_V = DATA_W'(DATA_W);
  localparam logic [CW-1:0]     DW_C = CW'(DATA_W);

  state_t            state, nxt_state;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic [3:0]        e_op;
  logic [DATA_W-1:0] e_a, e_b;
  logic [AW-1:0]     e_rd;
  logic              e_wb;
  logic [CW-1:0]     e_cnt;

  logic [DATA_W-1:0] core_res;
  logic              core_ovf, core_br;

  logic              e_done, c_wr, accept, new_shift;
  logic [DATA_W-1:0] c_result, sh_next;
  logic [DATA_W-1:0] rd_a, rd_b, a_op, b_op;
  logic [CW-1:0]     amt;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op          (e_op),
    .a           (e_a),
    .b           (e_b),
    .result      (core_res),
    .ovf         (core_ovf),
    .take_branch (core_br)
  );

  // During SHIFT, e_a is the working shift register.
  assign sh_next  = (e_op == OP_SRA) ? {e_a[DATA_W-1], e_a[DATA_W-1:1]}
                                     : {e_a[DATA_W-2:0], 1'b0};
  assign e_done   = (state == ST_EXEC) || (state == ST_SHIFT && e_cnt == CW'(1));
  assign c_result = (state == ST_SHIFT) ? sh_next : core_res;
  assign c_wr     = e_done && e_wb && op_writes(e_op) && !(ZERO_REG != 0 && e_rd == '0);

  // Forward only the completing ALU result; ext writes land after this read.
  assign rd_a = (c_wr && e_rd == rs1_addr) ? c_result : rf[rs1_addr];
  assign rd_b = (c_wr && e_rd == rs2_addr) ? c_result : rf[rs2_addr];
  assign a_op = src1_zero ? '0 : rd_a;
  assign b_op = src2_imm ? imm : rd_b;
  assign amt  = (b_op >= DW_V) ? DW_C : CW'(b_op);
  assign new_shift = op_is_shift(op) && (amt != '0);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE, ST_EXEC: in_ready = 1'b1;
      ST_SHIFT:         in_ready = (e_cnt == CW'(1));
      default:          ;
    endcase
    if (in_ready) begin
      if (in_valid) nxt_state = new_shift ? ST_SHIFT : ST_EXEC;
      else          nxt_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_op  <= '0;
      e_a   <= '0;
      e_b   <= '0;
      e_rd  <= '0;
      e_wb  <= 1'b0;
      e_cnt <= '0;
    end else begin
      if (state == ST_SHIFT) begin
        e_a   <= sh_next;
        e_cnt <= e_cnt - CW'(1);
      end
      if (accept) begin
        e_op  <= op;
        e_a   <= a_op;
        e_b   <= b_op;
        e_rd  <= rd_addr;
        e_wb  <= wb_en;
        e_cnt <= amt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_ovf         <= 1'b0;
      out_take_branch <= 1'b0;
    end else begin
      out_valid <= e_done;
      if (e_done) begin
        out_result      <= c_result;
        out_ovf         <= (state == ST_EXEC) && core_ovf;
        out_take_branch <= (state == ST_EXEC) && core_br;
      end
    end
  end

  // ALU writeback is the later assignment so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (ext_wr_en && !(ZERO_REG != 0 && ext_wr_addr == '0)) rf[ext_wr_addr] <= ext_wr_data;
      if (c_wr) rf[e_rd] <= c_result;
    end
  end

endmodule
